// File: rtl/alu_mul_seq.sv
// Opcode set of the shared combinational ALU, plus a shift-and-add
// multiplier sequencer that borrows that ALU to compute the low 32 bits
// of a 32x32 product (RV32M MUL semantics).

package alu_opcodes_pkg;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
endpackage

// Sequencer: IDLE -> CHECK -> (ADD ->) SHIFT -> CHECK ... -> DONE -> IDLE.
// The ALU is only driven in ADD (acc + mcand) and SHIFT (mcand << 1);
// every other state parks the ALU inputs at ADD 0,0 so the execute-stage
// mux sees quiet values.
module alu_mul_seq
    import alu_opcodes_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_result_o,
    output logic        busy_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  alu_op_o,
    input  logic [31:0] alu_result_i
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] acc_reg, acc_next;
    logic [31:0] mcand_reg, mcand_next;
    logic [31:0] mplier_reg, mplier_next;
    logic [5:0]  cnt_reg, cnt_next;

    // Early termination once no multiplier bits remain; in constant-time
    // mode this term is tied off so only the 32-shift count ends the loop.
    logic mplier_exhausted;

    generate
        if (EARLY_EXIT) begin : g_early_exit
            assign mplier_exhausted = (mplier_reg == 32'd0);
        end else begin : g_const_time
            assign mplier_exhausted = 1'b0;
        end
    endgenerate

    logic all_shifts_done;
    assign all_shifts_done = (cnt_reg == 6'd32);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= 32'd0;
            mcand_reg  <= 32'd0;
            mplier_reg <= 32'd0;
            cnt_reg    <= 6'd0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Next-state, datapath updates and all outputs, decoded from state.
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        mcand_next    = mcand_reg;
        mplier_next   = mplier_reg;
        cnt_next      = cnt_reg;
        req_ready_o   = 1'b0;
        resp_valid_o  = 1'b0;
        resp_result_o = 32'd0;
        busy_o        = 1'b1;
        alu_op_o      = ALU_ADD;
        alu_a_o       = 32'd0;
        alu_b_o       = 32'd0;

        case (state_reg)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    acc_next    = 32'd0;
                    mcand_next  = req_a_i;
                    mplier_next = req_b_i;
                    cnt_next    = 6'd0;
                    state_next  = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (all_shifts_done || mplier_exhausted) begin
                    state_next = ST_DONE;
                end else if (mplier_reg[0]) begin
                    state_next = ST_ADD;
                end else begin
                    state_next = ST_SHIFT;
                end
            end

            ST_ADD: begin
                alu_op_o   = ALU_ADD;
                alu_a_o    = acc_reg;
                alu_b_o    = mcand_reg;
                acc_next   = alu_result_i;
                state_next = ST_SHIFT;
            end

            ST_SHIFT: begin
                alu_op_o    = ALU_SLL;
                alu_a_o     = mcand_reg;
                alu_b_o     = 32'd1;
                mcand_next  = alu_result_i;
                // Multiplier shift is local; the ALU is busy with mcand.
                mplier_next = {1'b0, mplier_reg[31:1]};
                cnt_next    = cnt_reg + 6'd1;
                state_next  = ST_CHECK;
            end

            ST_DONE: begin
                resp_valid_o  = 1'b1;
                resp_result_o = acc_reg;
                if (resp_ready_i) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: one early-exit instance (unit 0) and one
// constant-time instance (unit 1), each paired with a small ALU model.
module tb_alu_mul_seq;
    import alu_opcodes_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_a      [2];
    logic [31:0] req_b      [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_result[2];
    logic        busy       [2];
    logic [31:0] alu_a      [2];
    logic [31:0] alu_b      [2];
    logic [4:0]  alu_op     [2];
    logic [31:0] alu_res    [2];

    always #5 clk = ~clk;

    alu_mul_seq #(.EARLY_EXIT(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_a_i(req_a[0]), .req_b_i(req_b[0]),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_result_o(resp_result[0]), .busy_o(busy[0]),
        .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]), .alu_op_o(alu_op[0]),
        .alu_result_i(alu_res[0])
    );

    alu_mul_seq #(.EARLY_EXIT(1'b0)) dut_ct (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_a_i(req_a[1]), .req_b_i(req_b[1]),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_result_o(resp_result[1]), .busy_o(busy[1]),
        .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]), .alu_op_o(alu_op[1]),
        .alu_result_i(alu_res[1])
    );

    // Combinational ALU model: only the two opcodes the sequencer uses.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_alu
            assign alu_res[gi] = (alu_op[gi] == ALU_ADD) ? alu_a[gi] + alu_b[gi] :
                                 (alu_op[gi] == ALU_SLL) ? alu_a[gi] << alu_b[gi][4:0] :
                                 32'd0;
        end
    endgenerate

    int total = 0;
    int bad   = 0;

    int lat_seen;
    int sll_seen;
    logic [4:0]  tr_op[$];
    logic [31:0] tr_a[$];
    logic [31:0] tr_b[$];

    typedef struct {
        int          u;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          sll;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_k(input int u, input logic [31:0] b);
        int k = 0;
        if (u == 1) return 32;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    function automatic int exp_lat(input int u, input logic [31:0] b);
        int p = 0;
        for (int i = 0; i < 32; i++) if (b[i]) p++;
        return 2 + 2 * exp_k(u, b) + p;
    endfunction

    // Entered at a negedge; leaves at the negedge after the accept edge.
    task automatic issue(input int u, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (!req_ready[u] && w < 200) begin
            @(posedge clk); @(negedge clk); w++;
        end
        if (!req_ready[u]) check("accept_ready", 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1;
        req_a[u] = a;
        req_b[u] = b;
        tr_op.delete(); tr_a.delete(); tr_b.delete();
        sll_seen = 0;
        @(posedge clk); @(negedge clk);
        req_valid[u] = 1'b0;
        req_a[u] = $urandom;
        req_b[u] = $urandom;
        lat_seen = 1;
    endtask

    // Counts edges from accept until resp_valid, logging active ALU ops.
    task automatic wait_resp(input int u);
        while (1) begin
            if (alu_op[u] == ALU_SLL) sll_seen++;
            if (alu_op[u] == ALU_SLL || alu_b[u] != 32'd0) begin
                tr_op.push_back(alu_op[u]);
                tr_a.push_back(alu_a[u]);
                tr_b.push_back(alu_b[u]);
            end
            if (resp_valid[u] || lat_seen >= 300) break;
            @(posedge clk); lat_seen++; @(negedge clk);
        end
    endtask

    task automatic check_resp(input int u, input string name, input logic [31:0] res,
                              input int lat, input int sll);
        check({name, "_valid"}, 32'(resp_valid[u]), 32'd1);
        check({name, "_res"}, resp_result[u], res);
        check({name, "_lat"}, lat_seen, lat);
        check({name, "_sll"}, sll_seen, sll);
        check({name, "_busy"}, 32'(busy[u]), 32'd1);
        check({name, "_rdy"}, 32'(req_ready[u]), 32'd0);
    endtask

    task automatic handshake(input int u, input string name, input logic [31:0] res, input int stall);
        for (int s = 0; s < stall; s++) begin
            check({name, "_hold_v"}, 32'(resp_valid[u]), 32'd1);
            check({name, "_hold_r"}, resp_result[u], res);
            @(posedge clk); @(negedge clk);
        end
        resp_ready[u] = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready[u] = 1'b0;
        check({name, "_post_v"}, 32'(resp_valid[u]), 32'd0);
        check({name, "_post_busy"}, 32'(busy[u]), 32'd0);
        check({name, "_post_rdy"}, 32'(req_ready[u]), 32'd1);
    endtask

    task automatic do_op(input int u, input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input int sll, input int stall);
        issue(u, a, b);
        wait_resp(u);
        $display("op %s u=%0d a=%08h b=%08h res=%08h lat=%0d sll=%0d", name, u, a, b,
                 resp_result[u], lat_seen, sll_seen);
        check_resp(u, name, res, lat, sll);
        handshake(u, name, res, stall);
    endtask

    initial begin
        vecs[0] = '{0, 32'd5,          32'd3,          32'd15,         8,  2};
        vecs[1] = '{0, 32'hDEADBEEF,   32'd0,          32'd0,          2,  0};
        vecs[2] = '{0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   98, 32};
        vecs[3] = '{1, 32'd7,          32'd2,          32'd14,         67, 32};
        vecs[4] = '{0, 32'd0,          32'h80000000,   32'd0,          67, 32};
        vecs[5] = '{0, 32'h12345678,   32'd1,          32'h12345678,   5,  1};
        vecs[6] = '{1, 32'd0,          32'd0,          32'd0,          66, 32};
        vecs[7] = '{0, 32'h00010000,   32'h00010000,   32'd0,          37, 17};
        vecs[8] = '{0, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1,   10, 3};
        vecs[9] = '{1, 32'd3,          32'd5,          32'd15,         68, 32};

        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_a[u] = 32'd0; req_b[u] = 32'd0; resp_ready[u] = 1'b0;
        end

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            check("rst_rdy", 32'(req_ready[u]), 32'd1);
            check("rst_valid", 32'(resp_valid[u]), 32'd0);
            check("rst_busy", 32'(busy[u]), 32'd0);
            check("rst_op", 32'(alu_op[u]), 32'(ALU_ADD));
            check("rst_a", alu_a[u], 32'd0);
            check("rst_b", alu_b[u], 32'd0);
            check("rst_res", resp_result[u], 32'd0);
        end
        @(posedge clk); @(negedge clk);

        // 5*3 with ALU operation trace ADD, SLL, ADD, SLL.
        do_op(0, "trace5x3", 32'd5, 32'd3, 32'd15, 8, 2, 0);
        check("trace_len", tr_op.size(), 32'd4);
        if (tr_op.size() == 4) begin
            check("trace_op0", 32'(tr_op[0]), 32'(ALU_ADD));
            check("trace_a0", tr_a[0], 32'd0);
            check("trace_b0", tr_b[0], 32'd5);
            check("trace_op1", 32'(tr_op[1]), 32'(ALU_SLL));
            check("trace_a1", tr_a[1], 32'd5);
            check("trace_b1", tr_b[1], 32'd1);
            check("trace_op2", 32'(tr_op[2]), 32'(ALU_ADD));
            check("trace_a2", tr_a[2], 32'd5);
            check("trace_b2", tr_b[2], 32'd10);
            check("trace_op3", 32'(tr_op[3]), 32'(ALU_SLL));
            check("trace_a3", tr_a[3], 32'd10);
        end

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].u, $sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].lat, vecs[i].sll, i % 3);
        end

        // Backpressure: 6*7 held 5 cycles while a second request waits.
        issue(0, 32'd6, 32'd7);
        wait_resp(0);
        $display("op bp u=0 a=00000006 b=00000007 res=%08h lat=%0d", resp_result[0], lat_seen);
        check_resp(0, "bp", 32'd42, 11, 3);
        for (int s = 0; s < 5; s++) begin
            req_valid[0] = 1'b1; req_a[0] = 32'd9; req_b[0] = 32'd11;
            check("bp_hold_v", 32'(resp_valid[0]), 32'd1);
            check("bp_hold_r", resp_result[0], 32'd42);
            check("bp_hold_rdy", 32'(req_ready[0]), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        resp_ready[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready[0] = 1'b0;
        check("bp_idle_rdy", 32'(req_ready[0]), 32'd1);
        check("bp_idle_v", 32'(resp_valid[0]), 32'd0);
        check("bp_idle_busy", 32'(busy[0]), 32'd0);
        tr_op.delete(); tr_a.delete(); tr_b.delete();
        sll_seen = 0;
        @(posedge clk); @(negedge clk);
        req_valid[0] = 1'b0; req_a[0] = $urandom; req_b[0] = $urandom;
        lat_seen = 1;
        wait_resp(0);
        $display("op bp2 u=0 a=00000009 b=0000000b res=%08h lat=%0d", resp_result[0], lat_seen);
        check_resp(0, "bp2", 32'd99, 13, 4);
        handshake(0, "bp2", 32'd99, 0);

        // Reset while in ADD for 100*255.
        issue(0, 32'd100, 32'd255);
        for (int w = 0; w < 20 && !(alu_op[0] == ALU_ADD && alu_b[0] != 32'd0); w++) begin
            @(posedge clk); @(negedge clk);
        end
        check("rst_mid_in_add", 32'(alu_b[0]), 32'd100);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        $display("op rst_mid u=0 busy=%0d valid=%0d", busy[0], resp_valid[0]);
        check("rst_mid_busy", 32'(busy[0]), 32'd0);
        check("rst_mid_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_mid_rdy", 32'(req_ready[0]), 32'd1);
        check("rst_mid_op", 32'(alu_op[0]), 32'(ALU_ADD));
        check("rst_mid_a", alu_a[0], 32'd0);
        do_op(0, "after_rst", 32'd3, 32'd4, 32'd12, 9, 3, 1);

        // Random operands with random response stalls.
        for (int i = 0; i < 640; i++) begin
            int u;
            logic [31:0] a, b;
            u = (i < 600) ? 0 : 1;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) b = 32'd0;
            do_op(u, $sformatf("rnd%0d", i), a, b, a * b, exp_lat(u, b), exp_k(u, b),
                  $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
